// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MEM-stage store path.
//   - DATA_W          : memory word width (only 32 is supported)
//   - SZ_BYTE/HALF/WORD: req_size encodings (2'b11 is handled as a word)
//   - state_e         : store_rmw_unit FSM states
//   - is_word()       : size decode helper
//   - is_misaligned() : natural-alignment test used by the trap build
// Optional feature macro: STORE_MISALIGN_TRAP_EN adds the ST_TRAP state.
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        ST_TRAP  = 3'd4
`endif
    } state_e;

    // Both 2'b10 and 2'b11 are word stores, so only the top bit matters.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    // Half needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        if (size[1] == 1'b1) begin
            bad = (addr_lo != 2'b00);
        end else if (size == SZ_HALF) begin
            bad = addr_lo[0];
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// -----------------------------------------------------------------------------
// store_lane_merge
// Purely combinational big-endian lane merge for sub-word stores.
// Ports:
//   old_word [31:0] in  : word currently held in memory
//   operand  [31:0] in  : register operand; narrowed to byte/half by size
//   size     [1:0]  in  : SZ_BYTE / SZ_HALF / word (10 or 11)
//   addr_lo  [1:0]  in  : byte offset within the word
//   merged   [31:0] out : old_word with the addressed lane(s) replaced
// Byte offset 0 is the most significant byte (big-endian). Half stores use
// only addr_lo[1]. Word size passes the operand through unchanged so a
// future store buffer can use this block for every store width.
// -----------------------------------------------------------------------------
module store_lane_merge
    import mips_mem_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] operand,
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] merged
);

    // Replace the addressed lane, keep every other lane from old_word.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00:   merged = {operand[7:0], old_word[23:0]};
                    2'b01:   merged = {old_word[31:24], operand[7:0], old_word[15:0]};
                    2'b10:   merged = {old_word[31:16], operand[7:0], old_word[7:0]};
                    2'b11:   merged = {old_word[31:8], operand[7:0]};
                    default: merged = old_word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1] == 1'b0) begin
                    merged = {operand[15:0], old_word[15:0]};
                end else begin
                    merged = {old_word[31:16], operand[15:0]};
                end
            end
            default: merged = operand;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// -----------------------------------------------------------------------------
// store_rmw_unit
// MEM-stage store unit for a word-wide data memory without byte enables.
// Word stores write directly; byte/half stores do read-modify-write.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_addr/data/size    : byte address, rt operand, size (00 b, 01 h, 1x w)
//   mem_addr              : word-aligned address, 0 when no strobe is active
//   mem_rd_en/mem_rdata   : read strobe; data returns the following cycle
//   mem_wr_en/mem_wdata   : write strobe and data (data 0 when no write)
//   busy                  : FSM not in IDLE
//   done                  : one-cycle pulse in the write cycle
//   misalign              : one-cycle trap pulse (STORE_MISALIGN_TRAP_EN only)
// Optional feature macro: STORE_MISALIGN_TRAP_EN. Without it misaligned half
// and word stores are silently aligned.
// -----------------------------------------------------------------------------
module store_rmw_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    import mips_mem_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [1:0]        size_q,  size_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] merged_s;
    logic [ADDR_W-1:0] aligned_s;

    assign aligned_s = {addr_q[ADDR_W-1:2], 2'b00};

    store_lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .operand  (data_q),
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .merged   (merged_s)
    );

    // State and request-context registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            size_q  <= 2'b00;
            merge_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            merge_q <= merge_d;
        end
    end

    // Next-state logic; the request is latched on acceptance in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        merge_d = merge_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    size_d = req_size;
`ifdef STORE_MISALIGN_TRAP_EN
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = ST_TRAP;
                    end else if (is_word(req_size)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
`else
                    if (is_word(req_size)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_MERGE;
            ST_MERGE: begin
                // mem_rdata holds the word requested in READ during this cycle.
                merge_d = merged_s;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
`ifdef STORE_MISALIGN_TRAP_EN
            ST_TRAP:  state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state register; address/data are zero off-strobe.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        done      = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
`ifdef STORE_MISALIGN_TRAP_EN
        misalign  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = aligned_s;
            end
            ST_MERGE: begin
                mem_rd_en = 1'b0;
            end
            ST_WRITE: begin
                mem_wr_en = 1'b1;
                done      = 1'b1;
                mem_addr  = aligned_s;
                if (is_word(size_q)) begin
                    mem_wdata = data_q;
                end else begin
                    mem_wdata = merge_q;
                end
            end
`ifdef STORE_MISALIGN_TRAP_EN
            ST_TRAP: begin
                misalign = 1'b1;
            end
`endif
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule
